// File: rtl/mem_copy_engine.sv
// Single-clock copy engine: moves LEN words from SRC_ADDR to DST_ADDR through a
// dual-port memory, one read/wait/write triple per word, with a read-timeout abort.
module mem_copy_engine #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_r_addr,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_o_data,
    input  logic              mem_valid
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cur_src_q, cur_src_d;
    logic [ADDR_W-1:0] cur_dst_q, cur_dst_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [ADDR_W:0]   words_done_q, words_done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              error_q, error_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [ADDR_W-1:0] mem_r_addr_q, mem_r_addr_d;
    logic [ADDR_W-1:0] mem_w_addr_q, mem_w_addr_d;
    logic [DATA_W-1:0] mem_w_data_q, mem_w_data_d;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through this block can infer a latch.
        state_d      = state_q;
        cur_src_d    = cur_src_q;
        cur_dst_d    = cur_dst_q;
        rem_d        = rem_q;
        words_done_d = words_done_q;
        data_d       = data_q;
        tmo_d        = tmo_q;
        error_d      = error_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_src_d    = src_addr;
                    cur_dst_d    = dst_addr;
                    rem_d        = len;
                    error_d      = 1'b0;
                    words_done_d = '0;
                    state_d      = (len == '0) ? S_DONE : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                tmo_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (mem_valid) begin
                    data_d  = mem_o_data;
                    state_d = S_WR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WR: begin
                cur_src_d    = cur_src_q + 1'b1;
                cur_dst_d    = cur_dst_q + 1'b1;
                words_done_d = words_done_q + 1'b1;
                rem_d        = rem_q - 1'b1;
                state_d      = (rem_q == (ADDR_W + 1)'(1)) ? S_DONE : S_RD_REQ;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        mem_re_d     = (state_d == S_RD_REQ);
        mem_we_d     = (state_d == S_WR);
        mem_en_d     = mem_re_d | mem_we_d;
        mem_r_addr_d = mem_re_d ? cur_src_d : '0;
        mem_w_addr_d = mem_we_d ? cur_dst_d : '0;
        mem_w_data_d = mem_we_d ? data_d : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_src_q    <= '0;
            cur_dst_q    <= '0;
            rem_q        <= '0;
            words_done_q <= '0;
            data_q       <= '0;
            tmo_q        <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_r_addr_q <= '0;
            mem_w_addr_q <= '0;
            mem_w_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_src_q    <= cur_src_d;
            cur_dst_q    <= cur_dst_d;
            rem_q        <= rem_d;
            words_done_q <= words_done_d;
            data_q       <= data_d;
            tmo_q        <= tmo_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            mem_r_addr_q <= mem_r_addr_d;
            mem_w_addr_q <= mem_w_addr_d;
            mem_w_data_q <= mem_w_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = words_done_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_re     = mem_re_q;
    assign mem_r_addr = mem_r_addr_q;
    assign mem_w_addr = mem_w_addr_q;
    assign mem_w_data = mem_w_data_q;

endmodule
